// File: rtl/axi_lite_master_interface.sv
// AXI4-Lite master bridge: one outstanding request/response transaction mapped onto AW/W/B or AR/R,
// with a per-state timeout that answers SLVERR when the slave hangs.
module axi_lite_master_interface #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int TRANS_W_STRB_W  = 4,
    parameter int TRANS_WR_RESP_W = 2,
    parameter int TRANS_PROT      = 3,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic                       i_req_write,
    input  logic [ADDR_WIDTH-1:0]      i_req_addr,
    input  logic [TRANS_PROT-1:0]      i_req_prot,
    input  logic [DATA_WIDTH-1:0]      i_req_wdata,
    input  logic [TRANS_W_STRB_W-1:0]  i_req_wstrb,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [DATA_WIDTH-1:0]      o_rsp_rdata,
    output logic [TRANS_WR_RESP_W-1:0] o_rsp_resp,
    output logic                       o_rsp_timeout,
    output logic [ADDR_WIDTH-1:0]      o_axi_awaddr,
    output logic [TRANS_PROT-1:0]      o_axi_awprot,
    output logic                       o_axi_awvalid,
    input  logic                       i_axi_awready,
    output logic [DATA_WIDTH-1:0]      o_axi_wdata,
    output logic [TRANS_W_STRB_W-1:0]  o_axi_wstrb,
    output logic                       o_axi_wvalid,
    input  logic                       i_axi_wready,
    input  logic [TRANS_WR_RESP_W-1:0] i_axi_bresp,
    input  logic                       i_axi_bvalid,
    output logic                       o_axi_bready,
    output logic [ADDR_WIDTH-1:0]      o_axi_araddr,
    output logic [TRANS_PROT-1:0]      o_axi_arprot,
    output logic                       o_axi_arvalid,
    input  logic                       i_axi_arready,
    input  logic [DATA_WIDTH-1:0]      i_axi_rdata,
    input  logic [TRANS_WR_RESP_W-1:0] i_axi_rresp,
    input  logic                       i_axi_rvalid,
    output logic                       o_axi_rready
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic             TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TRANS_WR_RESP_W-1:0] RESP_SLVERR = TRANS_WR_RESP_W'(2);
    localparam logic [DATA_WIDTH-1:0]      DATA_ZERO   = {DATA_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_AW_W = 3'd1,
        ST_WR_B    = 3'd2,
        ST_RD_AR   = 3'd3,
        ST_RD_R    = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    state_t                       state_r, state_next_s;
    logic [CNT_W-1:0]             cnt_r, cnt_next_s;
    logic                         aw_done_r, aw_done_next_s;
    logic                         w_done_r, w_done_next_s;
    logic                         req_ready_r, req_ready_next_s;
    logic                         awvalid_r, awvalid_next_s;
    logic                         wvalid_r, wvalid_next_s;
    logic                         bready_r, bready_next_s;
    logic                         arvalid_r, arvalid_next_s;
    logic                         rready_r, rready_next_s;
    logic [ADDR_WIDTH-1:0]        addr_r, addr_next_s;
    logic [TRANS_PROT-1:0]        prot_r, prot_next_s;
    logic [DATA_WIDTH-1:0]        wdata_r, wdata_next_s;
    logic [TRANS_W_STRB_W-1:0]    wstrb_r, wstrb_next_s;
    logic                         rsp_valid_r, rsp_valid_next_s;
    logic [DATA_WIDTH-1:0]        rsp_rdata_r, rsp_rdata_next_s;
    logic [TRANS_WR_RESP_W-1:0]   rsp_resp_r, rsp_resp_next_s;
    logic                         rsp_timeout_r, rsp_timeout_next_s;
    logic                         aw_all_s, w_all_s, expire_s, abort_s;

    // A channel counts as done if it finished earlier or handshakes this cycle.
    assign aw_all_s = aw_done_r | (awvalid_r & i_axi_awready);
    assign w_all_s  = w_done_r  | (wvalid_r  & i_axi_wready);
    assign expire_s = TMO_EN & (cnt_r == CNT_LAST);

    assign o_req_ready   = req_ready_r;
    assign o_rsp_valid   = rsp_valid_r;
    assign o_rsp_rdata   = rsp_rdata_r;
    assign o_rsp_resp    = rsp_resp_r;
    assign o_rsp_timeout = rsp_timeout_r;
    assign o_axi_awaddr  = addr_r;
    assign o_axi_awprot  = prot_r;
    assign o_axi_awvalid = awvalid_r;
    assign o_axi_wdata   = wdata_r;
    assign o_axi_wstrb   = wstrb_r;
    assign o_axi_wvalid  = wvalid_r;
    assign o_axi_bready  = bready_r;
    assign o_axi_araddr  = addr_r;
    assign o_axi_arprot  = prot_r;
    assign o_axi_arvalid = arvalid_r;
    assign o_axi_rready  = rready_r;

    // Next-state and next-output decode; every output is computed here and registered below.
    always_comb begin
        state_next_s       = state_r;
        cnt_next_s         = cnt_r;
        aw_done_next_s     = aw_done_r;
        w_done_next_s      = w_done_r;
        req_ready_next_s   = req_ready_r;
        awvalid_next_s     = awvalid_r;
        wvalid_next_s      = wvalid_r;
        bready_next_s      = bready_r;
        arvalid_next_s     = arvalid_r;
        rready_next_s      = rready_r;
        addr_next_s        = addr_r;
        prot_next_s        = prot_r;
        wdata_next_s       = wdata_r;
        wstrb_next_s       = wstrb_r;
        rsp_valid_next_s   = rsp_valid_r;
        rsp_rdata_next_s   = rsp_rdata_r;
        rsp_resp_next_s    = rsp_resp_r;
        rsp_timeout_next_s = rsp_timeout_r;
        abort_s            = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (i_req_valid) begin
                    addr_next_s      = i_req_addr;
                    prot_next_s      = i_req_prot;
                    wdata_next_s     = i_req_wdata;
                    wstrb_next_s     = i_req_wstrb;
                    aw_done_next_s   = 1'b0;
                    w_done_next_s    = 1'b0;
                    req_ready_next_s = 1'b0;
                    if (i_req_write) begin
                        state_next_s   = ST_WR_AW_W;
                        awvalid_next_s = 1'b1;
                        wvalid_next_s  = 1'b1;
                    end else begin
                        state_next_s   = ST_RD_AR;
                        arvalid_next_s = 1'b1;
                    end
                end else begin
                    req_ready_next_s = 1'b1;
                end
            end
            ST_WR_AW_W: begin
                if (aw_all_s && w_all_s) begin
                    state_next_s   = ST_WR_B;
                    awvalid_next_s = 1'b0;
                    wvalid_next_s  = 1'b0;
                    bready_next_s  = 1'b1;
                end else if (expire_s) begin
                    abort_s = 1'b1;
                end else begin
                    awvalid_next_s = ~aw_all_s;
                    wvalid_next_s  = ~w_all_s;
                    aw_done_next_s = aw_all_s;
                    w_done_next_s  = w_all_s;
                end
            end
            ST_WR_B: begin
                if (bready_r && i_axi_bvalid) begin
                    state_next_s       = ST_RSP;
                    bready_next_s      = 1'b0;
                    rsp_valid_next_s   = 1'b1;
                    rsp_rdata_next_s   = DATA_ZERO;
                    rsp_resp_next_s    = i_axi_bresp;
                    rsp_timeout_next_s = 1'b0;
                end else if (expire_s) begin
                    abort_s = 1'b1;
                end else begin
                    bready_next_s = 1'b1;
                end
            end
            ST_RD_AR: begin
                if (arvalid_r && i_axi_arready) begin
                    state_next_s   = ST_RD_R;
                    arvalid_next_s = 1'b0;
                    rready_next_s  = 1'b1;
                end else if (expire_s) begin
                    abort_s = 1'b1;
                end else begin
                    arvalid_next_s = 1'b1;
                end
            end
            ST_RD_R: begin
                if (rready_r && i_axi_rvalid) begin
                    state_next_s       = ST_RSP;
                    rready_next_s      = 1'b0;
                    rsp_valid_next_s   = 1'b1;
                    rsp_rdata_next_s   = i_axi_rdata;
                    rsp_resp_next_s    = i_axi_rresp;
                    rsp_timeout_next_s = 1'b0;
                end else if (expire_s) begin
                    abort_s = 1'b1;
                end else begin
                    rready_next_s = 1'b1;
                end
            end
            ST_RSP: begin
                if (i_rsp_ready) begin
                    state_next_s     = ST_IDLE;
                    rsp_valid_next_s = 1'b0;
                    req_ready_next_s = 1'b1;
                end else begin
                    rsp_valid_next_s = 1'b1;
                end
            end
            default: begin
                state_next_s     = ST_IDLE;
                req_ready_next_s = 1'b1;
                awvalid_next_s   = 1'b0;
                wvalid_next_s    = 1'b0;
                bready_next_s    = 1'b0;
                arvalid_next_s   = 1'b0;
                rready_next_s    = 1'b0;
                rsp_valid_next_s = 1'b0;
            end
        endcase

        // Hung slave: abandon the AXI side immediately, even mid-handshake, and answer SLVERR.
        if (abort_s) begin
            state_next_s       = ST_RSP;
            awvalid_next_s     = 1'b0;
            wvalid_next_s      = 1'b0;
            bready_next_s      = 1'b0;
            arvalid_next_s     = 1'b0;
            rready_next_s      = 1'b0;
            rsp_valid_next_s   = 1'b1;
            rsp_rdata_next_s   = DATA_ZERO;
            rsp_resp_next_s    = RESP_SLVERR;
            rsp_timeout_next_s = 1'b1;
            cnt_next_s         = CNT_ZERO;
        end else if (state_next_s != state_r) begin
            cnt_next_s = CNT_ZERO;
        end else if ((state_r == ST_IDLE) || (state_r == ST_RSP)) begin
            cnt_next_s = cnt_r;
        end else begin
            cnt_next_s = cnt_r + CNT_ONE;
        end
    end

    // FSM state, timeout counter and per-channel completion flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            aw_done_r <= aw_done_next_s;
            w_done_r  <= w_done_next_s;
        end
    end

    // Registered AXI, request-ready and response outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_ready_r   <= 1'b1;
            awvalid_r     <= 1'b0;
            wvalid_r      <= 1'b0;
            bready_r      <= 1'b0;
            arvalid_r     <= 1'b0;
            rready_r      <= 1'b0;
            addr_r        <= {ADDR_WIDTH{1'b0}};
            prot_r        <= {TRANS_PROT{1'b0}};
            wdata_r       <= DATA_ZERO;
            wstrb_r       <= {TRANS_W_STRB_W{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= DATA_ZERO;
            rsp_resp_r    <= {TRANS_WR_RESP_W{1'b0}};
            rsp_timeout_r <= 1'b0;
        end else begin
            req_ready_r   <= req_ready_next_s;
            awvalid_r     <= awvalid_next_s;
            wvalid_r      <= wvalid_next_s;
            bready_r      <= bready_next_s;
            arvalid_r     <= arvalid_next_s;
            rready_r      <= rready_next_s;
            addr_r        <= addr_next_s;
            prot_r        <= prot_next_s;
            wdata_r       <= wdata_next_s;
            wstrb_r       <= wstrb_next_s;
            rsp_valid_r   <= rsp_valid_next_s;
            rsp_rdata_r   <= rsp_rdata_next_s;
            rsp_resp_r    <= rsp_resp_next_s;
            rsp_timeout_r <= rsp_timeout_next_s;
        end
    end

endmodule

// File: tb/tb_axi_lite_master_interface.sv
// Directed bench for axi_lite_master_interface: a delay-programmable slave, a transaction-level
// expectation model, a per-cycle compare process and literal latency/boundary checks.
module tb_axi_lite_master_interface;

    localparam int TMO   = 16;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        i_req_valid = 1'b0, i_req_write = 1'b0;
    logic [31:0] i_req_addr = 32'h0, i_req_wdata = 32'h0;
    logic [2:0]  i_req_prot = 3'b000;
    logic [3:0]  i_req_wstrb = 4'b0000;
    logic        i_rsp_ready = 1'b0;
    logic        o_req_ready, o_rsp_valid, o_rsp_timeout;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_resp;
    logic [31:0] o_axi_awaddr, o_axi_wdata, o_axi_araddr;
    logic [2:0]  o_axi_awprot, o_axi_arprot;
    logic [3:0]  o_axi_wstrb;
    logic        o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_axi_arvalid, o_axi_rready;
    logic        i_axi_awready = 1'b0, i_axi_wready = 1'b0, i_axi_bvalid = 1'b0;
    logic        i_axi_arready = 1'b0, i_axi_rvalid = 1'b0;
    logic [1:0]  i_axi_bresp = 2'b00, i_axi_rresp = 2'b00;
    logic [31:0] i_axi_rdata = 32'h0;

    axi_lite_master_interface #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TRANS_W_STRB_W(4),
        .TRANS_WR_RESP_W(2), .TRANS_PROT(3), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_write(i_req_write),
        .i_req_addr(i_req_addr), .i_req_prot(i_req_prot), .i_req_wdata(i_req_wdata),
        .i_req_wstrb(i_req_wstrb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_resp(o_rsp_resp), .o_rsp_timeout(o_rsp_timeout),
        .o_axi_awaddr(o_axi_awaddr), .o_axi_awprot(o_axi_awprot), .o_axi_awvalid(o_axi_awvalid),
        .i_axi_awready(i_axi_awready),
        .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb), .o_axi_wvalid(o_axi_wvalid),
        .i_axi_wready(i_axi_wready),
        .i_axi_bresp(i_axi_bresp), .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready),
        .o_axi_araddr(o_axi_araddr), .o_axi_arprot(o_axi_arprot), .o_axi_arvalid(o_axi_arvalid),
        .i_axi_arready(i_axi_arready),
        .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp), .i_axi_rvalid(i_axi_rvalid),
        .o_axi_rready(o_axi_rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // slave behaviour: each ready/valid rises after the master has waited that many cycles
    int          aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;

    // transaction model
    bit          m_busy = 1'b0, m_write = 1'b0, m_exp_tmo = 1'b0;
    logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_exp_rdata = 32'h0;
    logic [2:0]  m_prot = 3'b000;
    logic [3:0]  m_wstrb = 4'b0000;
    logic [1:0]  m_exp_resp = 2'b00;

    int rise_aw = 0, rise_w = 0, rise_b = 0, rise_ar = 0, rise_r = 0;
    int fall_aw = 0, fall_w = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reactive AXI slave, updated away from the active edge.
    initial begin : slave
        int aw_s, w_s, b_s, ar_s, r_s;
        aw_s = 0; w_s = 0; b_s = 0; ar_s = 0; r_s = 0;
        forever begin
            @(negedge clk);
            i_axi_bresp = cfg_bresp;
            i_axi_rresp = cfg_rresp;
            i_axi_rdata = cfg_rdata;
            if (o_axi_awvalid === 1'b1) begin i_axi_awready = (aw_s >= aw_d); aw_s++; end
            else begin i_axi_awready = 1'b0; aw_s = 0; end
            if (o_axi_wvalid === 1'b1) begin i_axi_wready = (w_s >= w_d); w_s++; end
            else begin i_axi_wready = 1'b0; w_s = 0; end
            if (o_axi_bready === 1'b1) begin i_axi_bvalid = (b_s >= b_d); b_s++; end
            else begin i_axi_bvalid = 1'b0; b_s = 0; end
            if (o_axi_arvalid === 1'b1) begin i_axi_arready = (ar_s >= ar_d); ar_s++; end
            else begin i_axi_arready = 1'b0; ar_s = 0; end
            if (o_axi_rready === 1'b1) begin i_axi_rvalid = (r_s >= r_d); r_s++; end
            else begin i_axi_rvalid = 1'b0; r_s = 0; end
        end
    end

    // Per-cycle compare of the DUT against the transaction model; also timestamps edges.
    initial begin : monitor
        logic p_aw, p_w, p_b, p_ar, p_r;
        p_aw = 1'b0; p_w = 1'b0; p_b = 1'b0; p_ar = 1'b0; p_r = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_i !== 1'b1) begin
                if (o_axi_awvalid && !p_aw) rise_aw = cyc;
                if (!o_axi_awvalid && p_aw) fall_aw = cyc;
                if (o_axi_wvalid && !p_w) rise_w = cyc;
                if (!o_axi_wvalid && p_w) fall_w = cyc;
                if (o_axi_bready && !p_b) rise_b = cyc;
                if (o_axi_arvalid && !p_ar) rise_ar = cyc;
                if (o_axi_rready && !p_r) rise_r = cyc;
                p_aw = o_axi_awvalid; p_w = o_axi_wvalid; p_b = o_axi_bready;
                p_ar = o_axi_arvalid; p_r = o_axi_rready;

                chk("req_ready", {31'd0, o_req_ready}, {31'd0, !m_busy});
                if (!m_busy) begin
                    chk("idle_quiet", {26'd0, o_axi_awvalid, o_axi_wvalid, o_axi_bready,
                        o_axi_arvalid, o_axi_rready, o_rsp_valid}, 32'd0);
                end else begin
                    if (m_write) chk("wr_no_read_ch", {30'd0, o_axi_arvalid, o_axi_rready}, 32'd0);
                    else chk("rd_no_write_ch", {29'd0, o_axi_awvalid, o_axi_wvalid, o_axi_bready}, 32'd0);
                    if (o_axi_awvalid) begin
                        chk("awaddr", o_axi_awaddr, m_addr);
                        chk("awprot", {29'd0, o_axi_awprot}, {29'd0, m_prot});
                    end
                    if (o_axi_wvalid) begin
                        chk("wdata", o_axi_wdata, m_wdata);
                        chk("wstrb", {28'd0, o_axi_wstrb}, {28'd0, m_wstrb});
                    end
                    if (o_axi_arvalid) begin
                        chk("araddr", o_axi_araddr, m_addr);
                        chk("arprot", {29'd0, o_axi_arprot}, {29'd0, m_prot});
                    end
                    if (o_rsp_valid) begin
                        chk("rsp_resp", {30'd0, o_rsp_resp}, {30'd0, m_exp_resp});
                        chk("rsp_rdata", o_rsp_rdata, m_exp_rdata);
                        chk("rsp_timeout", {31'd0, o_rsp_timeout}, {31'd0, m_exp_tmo});
                        chk("rsp_axi_quiet", {27'd0, o_axi_awvalid, o_axi_wvalid, o_axi_bready,
                            o_axi_arvalid, o_axi_rready}, 32'd0);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        m_busy = 1'b0;
    endtask

    // Present one request with a given slave behaviour; returns the sample cycle it was presented in.
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [2:0] prot,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input int d_aw, input int d_w, input int d_b, input int d_ar, input int d_r,
                         input logic [1:0] resp, input logic [31:0] rd, output int acc);
        @(negedge clk);
        aw_d = d_aw; w_d = d_w; b_d = d_b; ar_d = d_ar; r_d = d_r;
        cfg_bresp = resp; cfg_rresp = resp; cfg_rdata = rd;
        m_write = wr; m_addr = addr; m_prot = prot; m_wdata = wd; m_wstrb = ws;
        m_exp_tmo   = wr ? ((d_aw >= TMO) || (d_w >= TMO) || (d_b >= TMO))
                         : ((d_ar >= TMO) || (d_r >= TMO));
        m_exp_resp  = m_exp_tmo ? 2'b10 : resp;
        m_exp_rdata = (m_exp_tmo || wr) ? 32'h0 : rd;
        i_req_valid = 1'b1; i_req_write = wr; i_req_addr = addr; i_req_prot = prot;
        i_req_wdata = wd; i_req_wstrb = ws;
        acc = cyc;
        @(posedge clk);
        #1;
        m_busy = 1'b1;
        i_req_valid = 1'b0; i_req_addr = ~addr; i_req_wdata = ~wd;
        i_req_prot = ~prot; i_req_wstrb = ~ws;
    endtask

    // Wait (bounded) for the response, hold it for dly cycles, then accept it.
    task automatic wait_rsp(input int dly, output logic [1:0] resp, output logic [31:0] rdata,
                            output logic tmo, output int rcyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_rsp_valid !== 1'b1 && n < 200);
        chk("rsp_arrives", {31'd0, o_rsp_valid}, 32'd1);
        rcyc = cyc; resp = o_rsp_resp; rdata = o_rsp_rdata; tmo = o_rsp_timeout;
        if (o_rsp_valid !== 1'b1) begin
            do_reset();
        end else begin
            repeat (dly) @(negedge clk);
            i_rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            i_rsp_ready = 1'b0;
            m_busy = 1'b0;
        end
    endtask

    initial begin : watchdog
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : main
        int acc, rc;
        logic [1:0]  gr;
        logic [31:0] gd;
        logic        gt;

        do_reset();
        @(negedge clk);
        chk("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
        chk("rst_outputs", {26'd0, o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_axi_arvalid,
            o_axi_rready, o_rsp_valid}, 32'd0);
        chk("rst_awaddr", o_axi_awaddr, 32'd0);
        chk("rst_rdata", o_rsp_rdata, 32'd0);

        // minimum-latency write
        issue(1'b1, 32'h0000_1000, 3'b000, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0, NEVER, NEVER, 2'b00, 32'h0, acc);
        wait_rsp(0, gr, gd, gt, rc);
        chk("w1_aw_lat", rise_aw - acc, 32'd1);
        chk("w1_w_lat", rise_w - acc, 32'd1);
        chk("w1_b_lat", rise_b - acc, 32'd2);
        chk("w1_rsp_lat", rc - acc, 32'd3);
        chk("w1_resp", {30'd0, gr}, 32'd0);
        chk("w1_tmo", {31'd0, gt}, 32'd0);

        // awready delayed 3 cycles, wready immediate
        issue(1'b1, 32'h0000_3000, 3'b010, 32'h1234_5678, 4'b1100, 3, 0, 0, NEVER, NEVER, 2'b00, 32'h0, acc);
        wait_rsp(2, gr, gd, gt, rc);
        chk("w2_w_fall", fall_w - acc, 32'd2);
        chk("w2_aw_fall", fall_aw - acc, 32'd5);
        chk("w2_b_rise", rise_b - acc, 32'd5);
        chk("w2_rsp_lat", rc - acc, 32'd6);

        // read with arready after 2 cycles
        issue(1'b0, 32'h0000_2000, 3'b001, 32'h0, 4'b0000, NEVER, NEVER, NEVER, 2, 0, 2'b00, 32'hCAFE_1234, acc);
        wait_rsp(3, gr, gd, gt, rc);
        chk("r1_rsp_lat", rc - acc, 32'd5);
        chk("r1_rdata", gd, 32'hCAFE_1234);
        chk("r1_resp", {30'd0, gr}, 32'd0);

        // slave never returns rvalid
        issue(1'b0, 32'h0000_2004, 3'b000, 32'h0, 4'b0000, NEVER, NEVER, NEVER, 0, NEVER, 2'b00, 32'h5555_AAAA, acc);
        wait_rsp(0, gr, gd, gt, rc);
        chk("r2_tmo_lat", rc - rise_r, 32'd16);
        chk("r2_resp", {30'd0, gr}, 32'd2);
        chk("r2_tmo", {31'd0, gt}, 32'd1);
        chk("r2_rdata", gd, 32'd0);

        // bvalid exactly on the expiry cycle: normal response wins
        issue(1'b1, 32'h0000_4000, 3'b000, 32'h0BAD_F00D, 4'b0011, 0, 0, 15, NEVER, NEVER, 2'b01, 32'h0, acc);
        wait_rsp(0, gr, gd, gt, rc);
        chk("w3_rsp_lat", rc - rise_b, 32'd16);
        chk("w3_resp", {30'd0, gr}, 32'd1);
        chk("w3_tmo", {31'd0, gt}, 32'd0);

        // bvalid one cycle too late: timeout
        issue(1'b1, 32'h0000_4004, 3'b000, 32'h0000_0001, 4'b0001, 0, 0, 16, NEVER, NEVER, 2'b01, 32'h0, acc);
        wait_rsp(0, gr, gd, gt, rc);
        chk("w4_rsp_lat", rc - rise_b, 32'd16);
        chk("w4_resp", {30'd0, gr}, 32'd2);
        chk("w4_tmo", {31'd0, gt}, 32'd1);

        // AW/W both finishing on the expiry cycle, then AW one cycle too late
        issue(1'b1, 32'h0000_5000, 3'b111, 32'h7777_0000, 4'b1010, 15, 15, 0, NEVER, NEVER, 2'b00, 32'h0, acc);
        wait_rsp(0, gr, gd, gt, rc);
        chk("w5_b_rise", rise_b - acc, 32'd17);
        chk("w5_tmo", {31'd0, gt}, 32'd0);
        issue(1'b1, 32'h0000_5004, 3'b000, 32'h7777_0001, 4'b0101, 16, 0, 0, NEVER, NEVER, 2'b00, 32'h0, acc);
        wait_rsp(0, gr, gd, gt, rc);
        chk("w6_rsp_lat", rc - rise_aw, 32'd16);
        chk("w6_tmo", {31'd0, gt}, 32'd1);

        // slave error codes pass through
        issue(1'b0, 32'h0000_6000, 3'b000, 32'h0, 4'b0000, NEVER, NEVER, NEVER, 1, 1, 2'b11, 32'hA5A5_0001, acc);
        wait_rsp(0, gr, gd, gt, rc);
        chk("r3_decerr", {30'd0, gr}, 32'd3);
        chk("r3_rdata", gd, 32'hA5A5_0001);
        issue(1'b1, 32'h0000_6004, 3'b000, 32'h1, 4'b1111, 1, 2, 1, NEVER, NEVER, 2'b10, 32'h0, acc);
        wait_rsp(1, gr, gd, gt, rc);
        chk("w7_slverr", {30'd0, gr}, 32'd2);
        chk("w7_tmo", {31'd0, gt}, 32'd0);

        // reset in the middle of a write
        issue(1'b1, 32'h0000_7000, 3'b000, 32'hFEED_0000, 4'b1111, NEVER, NEVER, 0, NEVER, NEVER, 2'b00, 32'h0, acc);
        repeat (3) @(negedge clk);
        chk("mid_awvalid", {31'd0, o_axi_awvalid}, 32'd1);
        do_reset();
        @(negedge clk);
        chk("post_rst_valids", {29'd0, o_axi_awvalid, o_axi_wvalid, o_rsp_valid}, 32'd0);
        chk("post_rst_ready", {31'd0, o_req_ready}, 32'd1);
        repeat (4) @(negedge clk);
        chk("post_rst_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
        issue(1'b1, 32'h0000_7004, 3'b001, 32'h0123_4567, 4'b1111, 0, 0, 0, NEVER, NEVER, 2'b00, 32'h0, acc);
        wait_rsp(0, gr, gd, gt, rc);
        chk("after_rst_lat", rc - acc, 32'd3);
        chk("after_rst_resp", {30'd0, gr}, 32'd0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
